regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (we_RF/A3/WD3) among three requesters:
  - pipeline writeback (wb)
  - late load return (mem)
  - debug port (dbg)
- Also sequences a post-reset clear sweep of the register file.
- Sits between the core's writeback/load/debug logic and registerMemory; the read ports (A1/A2) are untouched.

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rf_arb_starve_ctr.sv | 29 ++
 rtl/regfile_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
// Optional feature macro used by the arbiter: RF_INIT_CLEAR_EN.
package rf_arb_pkg;

    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 32;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } rf_arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_MEM,
        GNT_DBG
    } rf_grant_t;

endpackage

// File: rtl/rf_arb_starve_ctr.sv
// Saturating wait counter for the debug requester; sat promotes dbg over mem.
module rf_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CW-1:0] cnt;

    // Count mem wins while dbg waits; clear wins over increment, stop at LIMIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == CW'(LIMIT));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port among writeback, late load
// return and debug, and optionally sequences a post-reset clear sweep.
// Optional feature macro: RF_INIT_CLEAR_EN (defined: INIT sweep of x1..xN-1;
// undefined: reset enters RUN directly, init_busy tied low).
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NUM_REGS     = RF_NUM_REGS,
    parameter int unsigned DATA_W       = RF_DATA_W,
    parameter int unsigned ADDR_W       = RF_ADDR_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              we_RF,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              init_busy,
    output logic              wb_err
);

    rf_arb_state_t     state;
    rf_grant_t         grant;
    logic              starve_sat;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_writable;

`ifdef RF_INIT_CLEAR_EN
    logic [ADDR_W-1:0] sweep_cnt;

    // INIT walks the sweep counter 1..NUM_REGS-1, then hands over to RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_INIT;
            sweep_cnt <= ADDR_W'(1);
        end else if (state == ST_INIT) begin
            if (sweep_cnt == ADDR_W'(NUM_REGS - 1)) begin
                state <= ST_RUN;
            end else begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    assign init_busy = (state == ST_INIT);
`else
    assign state     = ST_RUN;
    assign init_busy = 1'b0;
`endif

    // Grant selection: wb always first, then mem > dbg unless dbg has starved.
    // Reset withholds every grant so an aborted handshake is never acknowledged.
    always_comb begin
        grant = GNT_NONE;
        if (rst && (state == ST_RUN)) begin
            if (wb_valid) begin
                grant = GNT_WB;
            end else if (mem_valid && dbg_valid && starve_sat) begin
                grant = GNT_DBG;
            end else if (mem_valid) begin
                grant = GNT_MEM;
            end else if (dbg_valid) begin
                grant = GNT_DBG;
            end
        end
    end

    assign mem_ready = (grant == GNT_MEM);
    assign dbg_ready = (grant == GNT_DBG);

    // Route the winner's address/data toward the output register.
    always_comb begin
        sel_addr = wb_addr;
        sel_data = wb_data;
        case (grant)
            GNT_MEM: begin
                sel_addr = mem_addr;
                sel_data = mem_data;
            end
            GNT_DBG: begin
                sel_addr = dbg_addr;
                sel_data = dbg_data;
            end
            default: ;
        endcase
    end

    // x0 and addresses past the last register complete the handshake but never write.
    assign sel_writable = (sel_addr != '0) &&
                          ({1'b0, sel_addr} < (ADDR_W + 1)'(NUM_REGS));

    rf_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (dbg_valid && (grant == GNT_MEM)),
        .clr ((grant == GNT_DBG) || !dbg_valid),
        .sat (starve_sat)
    );

    // Write-port register: sweep writes during INIT, granted request in RUN,
    // otherwise drop the enable and keep the last address/data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_RF <= 1'b0;
            A3    <= '0;
            WD3   <= '0;
`ifdef RF_INIT_CLEAR_EN
        end else if (state == ST_INIT) begin
            we_RF <= 1'b1;
            A3    <= sweep_cnt;
            WD3   <= '0;
`endif
        end else if (grant != GNT_NONE) begin
            we_RF <= sel_writable;
            A3    <= sel_addr;
            WD3   <= sel_data;
        end else begin
            we_RF <= 1'b0;
        end
    end

    // Sticky flag for writeback requests lost while the sweep owns the port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_err <= 1'b0;
        end else if ((state == ST_INIT) && wb_valid) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a queue of expected write-port
// values; the sweep checks are included when RF_INIT_CLEAR_EN is defined.
module tb_regfile_write_arbiter;
    import rf_arb_pkg::*;

    localparam int unsigned AW = RF_ADDR_W;
    localparam int unsigned DW = RF_DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid, mem_valid, dbg_valid;
    logic [AW-1:0] wb_addr, mem_addr, dbg_addr;
    logic [DW-1:0] wb_data, mem_data, dbg_data;
    logic          mem_ready, dbg_ready;
    logic          we_RF;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          init_busy, wb_err;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REGS     (32),
        .DATA_W       (32),
        .ADDR_W       (5),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .dbg_valid (dbg_valid),
        .dbg_ready (dbg_ready),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .we_RF     (we_RF),
        .A3        (A3),
        .WD3       (WD3),
        .init_busy (init_busy),
        .wb_err    (wb_err)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           expq[$];
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    int            vectors = 0;
    int            miscompares = 0;
    int unsigned   mem_seq = 0;
    int unsigned   dbg_seq = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.we = we;
        e.a  = a;
        e.d  = d;
        expq.push_back(e);
        exp_a = a;
        exp_d = d;
    endtask

    task automatic expect_idle();
        wr_t e;
        e.we = 1'b0;
        e.a  = exp_a;
        e.d  = exp_d;
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the combinational readies for the inputs just driven, clock once,
    // then compare the write port against the oldest queued expectation.
    task automatic cycle(input string tag, input logic mr, input logic dr);
        wr_t e;
        #1;
        chk({tag, ".mem_ready"}, 64'(mem_ready), 64'(mr));
        chk({tag, ".dbg_ready"}, 64'(dbg_ready), 64'(dr));
        tick();
        vectors++;
        assert (expq.size() != 0) else begin
            miscompares++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk({tag, ".we_RF"}, 64'(we_RF), 64'(e.we));
            chk({tag, ".A3"},    64'(A3),    64'(e.a));
            chk({tag, ".WD3"},   64'(WD3),   64'(e.d));
        end
    endtask

    task automatic mem_wins(input string tag, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            mem_addr = AW'(10 + (mem_seq % 16));
            mem_data = 32'hB000_0000 + mem_seq;
            mem_seq++;
            expect_wr(1'b1, mem_addr, mem_data);
            cycle(tag, 1'b1, 1'b0);
        end
    endtask

    task automatic dbg_win(input string tag);
        expect_wr(1'b1, dbg_addr, dbg_data);
        cycle(tag, 1'b0, 1'b1);
        dbg_seq++;
        dbg_addr = AW'(26 + (dbg_seq % 4));
        dbg_data = 32'hD000_0000 + dbg_seq;
    endtask

    initial begin
        rst       = 1'b0;
        wb_valid  = 1'b0;
        mem_valid = 1'b0;
        dbg_valid = 1'b0;
        wb_addr   = '0;
        mem_addr  = '0;
        dbg_addr  = '0;
        wb_data   = '0;
        mem_data  = '0;
        dbg_data  = '0;
        exp_a     = '0;
        exp_d     = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.we_RF",  64'(we_RF),  64'd0);
        chk("reset.A3",     64'(A3),     64'd0);
        chk("reset.WD3",    64'(WD3),    64'd0);
        chk("reset.wb_err", 64'(wb_err), 64'd0);
`ifdef RF_INIT_CLEAR_EN
        chk("reset.init_busy", 64'(init_busy), 64'd1);
`else
        chk("reset.init_busy", 64'(init_busy), 64'd0);
`endif
        rst = 1'b1;

`ifdef RF_INIT_CLEAR_EN
        // Sweep x1..x31 with zero data; a wb request at step 5 must be dropped.
        for (int unsigned i = 1; i <= 31; i++) begin
            if (i == 5) begin
                wb_valid  = 1'b1;
                wb_addr   = AW'(3);
                wb_data   = 32'h5555_5555;
                mem_valid = 1'b1;
                dbg_valid = 1'b1;
                #1;
                chk("init.mem_ready", 64'(mem_ready), 64'd0);
                chk("init.dbg_ready", 64'(dbg_ready), 64'd0);
            end
            tick();
            if (i == 5) begin
                wb_valid  = 1'b0;
                mem_valid = 1'b0;
                dbg_valid = 1'b0;
            end
            chk($sformatf("sweep%0d.we_RF", i), 64'(we_RF), 64'd1);
            chk($sformatf("sweep%0d.A3", i),    64'(A3),    64'(i));
            chk($sformatf("sweep%0d.WD3", i),   64'(WD3),   64'd0);
            chk($sformatf("sweep%0d.init_busy", i), 64'(init_busy), 64'(i < 31));
            chk($sformatf("sweep%0d.wb_err", i),    64'(wb_err),    64'(i >= 5));
        end
        exp_a = AW'(31);
        exp_d = '0;
        expect_idle();
        cycle("post_sweep", 1'b0, 1'b0);
`else
        expect_idle();
        cycle("first_run", 1'b0, 1'b0);
        chk("run.init_busy", 64'(init_busy), 64'd0);
`endif

        // Three-way conflict: wb first, then mem, then dbg alone.
        wb_valid  = 1'b1; wb_addr  = AW'(7); wb_data  = 32'h0000_AAAA;
        mem_valid = 1'b1; mem_addr = AW'(8); mem_data = 32'h0000_BBBB;
        dbg_valid = 1'b1; dbg_addr = AW'(9); dbg_data = 32'h0000_CCCC;
        expect_wr(1'b1, AW'(7), 32'h0000_AAAA);
        cycle("conflict_wb", 1'b0, 1'b0);
        wb_valid = 1'b0;
        expect_wr(1'b1, AW'(8), 32'h0000_BBBB);
        cycle("conflict_mem", 1'b1, 1'b0);
        mem_valid = 1'b0;
        dbg_win("conflict_dbg");
        dbg_valid = 1'b0;
        expect_idle();
        cycle("idle_hold", 1'b0, 1'b0);

        // Starvation: four mem wins, then dbg promoted, then mem again.
        mem_valid = 1'b1;
        dbg_valid = 1'b1;
        mem_wins("starve_mem", 4);
        mem_addr = AW'(14);
        dbg_win("starve_dbg");
        mem_wins("after_promo", 1);

        // A wb win must not disturb the starve count (at 1 here).
        mem_wins("pre_wb", 2);
        wb_valid = 1'b1; wb_addr = AW'(3); wb_data = 32'h0000_3333;
        expect_wr(1'b1, AW'(3), 32'h0000_3333);
        cycle("wb_hold_starve", 1'b0, 1'b0);
        wb_valid = 1'b0;
        mem_wins("post_wb", 1);
        dbg_win("post_wb_dbg");

        // Dropping dbg_valid resets the count: four full mem wins needed again.
        mem_wins("pre_drop", 2);
        dbg_valid = 1'b0;
        mem_wins("drop", 1);
        dbg_valid = 1'b1;
        mem_wins("refill", 4);
        dbg_win("refill_dbg");
        mem_valid = 1'b0;
        dbg_valid = 1'b0;

        // x0 writes handshake but keep we_RF low.
        mem_valid = 1'b1; mem_addr = '0; mem_data = 32'h0000_1234;
        expect_wr(1'b0, '0, 32'h0000_1234);
        cycle("x0_mem", 1'b1, 1'b0);
        mem_valid = 1'b0;
        wb_valid = 1'b1; wb_addr = '0; wb_data = 32'h0000_4321;
        expect_wr(1'b0, '0, 32'h0000_4321);
        cycle("x0_wb", 1'b0, 1'b0);
        wb_valid = 1'b0;
        expect_idle();
        cycle("idle_end", 1'b0, 1'b0);

        vectors++;
        assert (expq.size() == 0) else begin
            miscompares++;
            $error("FAIL queue_drain: observed %0d expected 0", expq.size());
        end

`ifdef RF_INIT_CLEAR_EN
        chk("wb_err_sticky", 64'(wb_err), 64'd1);
`else
        chk("wb_err_never", 64'(wb_err), 64'd0);
`endif

        // Reset during a mem request: no write of that data, state restarts.
        mem_valid = 1'b1; mem_addr = AW'(5); mem_data = 32'h0000_5A5A;
        rst = 1'b0;
        tick();
        mem_valid = 1'b0;
        chk("midrst.we_RF",  64'(we_RF),  64'd0);
        chk("midrst.A3",     64'(A3),     64'd0);
        chk("midrst.WD3",    64'(WD3),    64'd0);
        chk("midrst.wb_err", 64'(wb_err), 64'd0);
`ifdef RF_INIT_CLEAR_EN
        chk("midrst.init_busy", 64'(init_busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("resweep.we_RF", 64'(we_RF), 64'd1);
        chk("resweep.A3",    64'(A3),    64'd1);
`else
        chk("midrst.init_busy", 64'(init_busy), 64'd0);
        rst = 1'b1;
        tick();
        chk("after_rst.we_RF", 64'(we_RF), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
